// File: rtl/mult_requester.sv
// Operand-pair requester: 2-entry input FIFO feeding a handshaked multiplier, one product in flight.
// Optional REQ timeout abort is compiled in with MULT_REQUESTER_TIMEOUT_EN.
module mult_requester #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 valid_data,
  input  logic                 Done_Flag,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_err
);

  // state | meaning
  // IDLE  | waiting for a queued pair or a stale Done_Flag
  // REQ   | valid_data high, operands held, waiting for Done_Flag
  // ACK   | ack high until Done_Flag drops (drain_q: stale result, no response)
  // RESP  | out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, REQ, ACK, RESP} state_t;

  state_t state_q, state_d;
  logic   drain_q, drain_d;

  logic [WIDTH-1:0] fifo_a [2];
  logic [WIDTH-1:0] fifo_b [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             push, pop, full, empty;

  logic [WIDTH-1:0]   mul_a_d, mul_b_d;
  logic               valid_d, ack_d, out_valid_d;
  logic [2*WIDTH-1:0] out_product_d;

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign in_ready = !full && !Reset;
  assign push     = in_valid && in_ready;

`ifdef MULT_REQUESTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign out_err = err_q;
`else
  // Without the timeout there is no abort path, so the error flag is tied low.
  assign out_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_a[wr_ptr_q] <= in_a;
      fifo_b[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    pop           = 1'b0;
    mul_a_d       = mul_a;
    mul_b_d       = mul_b;
    valid_d       = valid_data;
    ack_d         = ack;
    out_valid_d   = out_valid;
    out_product_d = out_product;
`ifdef MULT_REQUESTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (Done_Flag) begin
          ack_d   = 1'b1;
          drain_d = 1'b1;
          state_d = ACK;
        end else if (!empty) begin
          pop     = 1'b1;
          mul_a_d = fifo_a[rd_ptr_q];
          mul_b_d = fifo_b[rd_ptr_q];
          valid_d = 1'b1;
          state_d = REQ;
`ifdef MULT_REQUESTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (Done_Flag) begin
          out_product_d = mul_product;
          valid_d       = 1'b0;
          ack_d         = 1'b1;
          drain_d       = 1'b0;
          state_d       = ACK;
`ifdef MULT_REQUESTER_TIMEOUT_EN
          err_d         = 1'b0;
`endif
        end
`ifdef MULT_REQUESTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          valid_d       = 1'b0;
          out_product_d = '0;
          err_d         = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: begin
        if (!Done_Flag) begin
          ack_d = 1'b0;
          if (drain_q) begin
            drain_d = 1'b0;
            state_d = IDLE;
          end else begin
            out_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      valid_data  <= 1'b0;
      ack         <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
`ifdef MULT_REQUESTER_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      mul_a       <= mul_a_d;
      mul_b       <= mul_b_d;
      valid_data  <= valid_d;
      ack         <= ack_d;
      out_valid   <= out_valid_d;
      out_product <= out_product_d;
`ifdef MULT_REQUESTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule
